decode_stage_param: RTL and testbench

DECODE_STAGE_PARAM -- requirements
Module: decode_stage_param

---
 rtl/decode_stage_param_if.sv | 38 +++
 rtl/decode_stage_param.sv | 100 ++++++++++
 tb/tb_decode_stage_param.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_param_if.sv
// rtl/decode_stage_param_if.sv - decode-to-EX bundle: decode inputs, writeback port and ID/EX outputs
interface decode_stage_param_if #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int CTRL_W = 9
);
   localparam int AW = $clog2(NREGS);

   logic [31:0]       InstrD;
   logic [XLEN-1:0]   PC_DE;
   logic              VALID_D;
   logic [CTRL_W-1:0] CTRL_D;
   logic              STALL;
   logic              FLUSH;
   logic              WB_WE;
   logic [AW-1:0]     WB_A;
   logic [XLEN-1:0]   WB_D;
   logic              READY_D;
   logic              VALID_EX;
   logic [CTRL_W-1:0] CTRL_EX;
   logic [XLEN-1:0]   D1;
   logic [XLEN-1:0]   D2;
   logic [24:0]       Imm;
   logic [XLEN-1:0]   PC_EX;
   logic [4:0]        RS1_EX;
   logic [4:0]        RS2_EX;
   logic [4:0]        RD_EX;

   modport master (
      output InstrD, PC_DE, VALID_D, CTRL_D, STALL, FLUSH, WB_WE, WB_A, WB_D,
      input  READY_D, VALID_EX, CTRL_EX, D1, D2, Imm, PC_EX, RS1_EX, RS2_EX, RD_EX
   );

   modport slave (
      input  InstrD, PC_DE, VALID_D, CTRL_D, STALL, FLUSH, WB_WE, WB_A, WB_D,
      output READY_D, VALID_EX, CTRL_EX, D1, D2, Imm, PC_EX, RS1_EX, RS2_EX, RD_EX
   );
endinterface

// File: rtl/decode_stage_param.sv
// rtl/decode_stage_param.sv - decode stage: register file with WB bypass and ID/EX pipeline register
module decode_stage_param #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int CTRL_W = 9
) (
   input logic                 clk,
   input logic                 rst,
   decode_stage_param_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]   rf [NREGS];
   logic [4:0]        rs1, rs2, rd, wb_idx;
   logic [XLEN-1:0]   rd1, rd2;
   logic              v_ex;
   logic [CTRL_W-1:0] ctrl_ex;
   logic [XLEN-1:0]   d1_ex, d2_ex, pc_ex;
   logic [24:0]       imm_ex;
   logic [4:0]        rs1_ex, rs2_ex, rd_ex;
   logic              refresh1, refresh2;
   logic              unused_opcode;

   function automatic logic src_ok(input logic [4:0] idx);
      return (idx != 5'd0) && (int'(idx) < NREGS);
   endfunction

   function automatic logic wb_hit(input logic [4:0] idx, input logic we, input logic [4:0] wa);
      return we && src_ok(idx) && (wa == idx);
   endfunction

   assign rs1           = bus.InstrD[19:15];
   assign rs2           = bus.InstrD[24:20];
   assign rd            = bus.InstrD[11:7];
   assign wb_idx        = 5'(bus.WB_A);
   assign unused_opcode = ^bus.InstrD[6:0];

   // Out-of-range and x0 sources read 0 before any bypass is considered.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (src_ok(rs1))
         rd1 = wb_hit(rs1, bus.WB_WE, wb_idx) ? bus.WB_D : rf[rs1[AW-1:0]];
      if (src_ok(rs2))
         rd2 = wb_hit(rs2, bus.WB_WE, wb_idx) ? bus.WB_D : rf[rs2[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++)
            rf[i] <= '0;
      end else if (bus.WB_WE && (bus.WB_A != '0)) begin
         rf[bus.WB_A] <= bus.WB_D;
      end
   end

   // A stalled EX instruction must not keep a stale operand that WB produces meanwhile.
   assign refresh1 = v_ex && wb_hit(rs1_ex, bus.WB_WE, wb_idx);
   assign refresh2 = v_ex && wb_hit(rs2_ex, bus.WB_WE, wb_idx);

   always_ff @(posedge clk) begin
      if (!rst || bus.FLUSH) begin
         v_ex    <= 1'b0;
         ctrl_ex <= '0;
         d1_ex   <= '0;
         d2_ex   <= '0;
         imm_ex  <= '0;
         pc_ex   <= '0;
         rs1_ex  <= '0;
         rs2_ex  <= '0;
         rd_ex   <= '0;
      end else if (bus.STALL) begin
         if (refresh1)
            d1_ex <= bus.WB_D;
         if (refresh2)
            d2_ex <= bus.WB_D;
      end else begin
         v_ex    <= bus.VALID_D;
         ctrl_ex <= bus.VALID_D ? bus.CTRL_D : '0;
         d1_ex   <= rd1;
         d2_ex   <= rd2;
         imm_ex  <= bus.InstrD[31:7];
         pc_ex   <= bus.PC_DE;
         rs1_ex  <= rs1;
         rs2_ex  <= rs2;
         rd_ex   <= rd;
      end
   end

   assign bus.READY_D  = !bus.STALL;
   assign bus.VALID_EX = v_ex;
   assign bus.CTRL_EX  = ctrl_ex;
   assign bus.D1       = d1_ex;
   assign bus.D2       = d2_ex;
   assign bus.Imm      = imm_ex;
   assign bus.PC_EX    = pc_ex;
   assign bus.RS1_EX   = rs1_ex;
   assign bus.RS2_EX   = rs2_ex;
   assign bus.RD_EX    = rd_ex;
endmodule

// File: tb/tb_decode_stage_param.sv
// tb/tb_decode_stage_param.sv - bench for decode_stage_param: directed literals on defaults, random vs model on NREGS=16/XLEN=64
module tb_decode_stage_param;
   logic clk = 1'b0;
   logic rst0 = 1'b1;
   logic rst1 = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   decode_stage_param_if #(.XLEN(32), .NREGS(32), .CTRL_W(9)) b0 ();
   decode_stage_param_if #(.XLEN(64), .NREGS(16), .CTRL_W(9)) b1 ();

   decode_stage_param #(.XLEN(32), .NREGS(32), .CTRL_W(9)) u0 (.clk(clk), .rst(rst0), .bus(b0));
   decode_stage_param #(.XLEN(64), .NREGS(16), .CTRL_W(9)) u1 (.clk(clk), .rst(rst1), .bus(b1));

   // Reference state for u1: architectural register contents and the expected EX slot.
   logic [63:0] m_rf [16];
   logic        m_valid;
   logic [8:0]  m_ctrl;
   logic [63:0] m_d1, m_d2, m_pc;
   logic [24:0] m_imm;
   logic [4:0]  m_rs1, m_rs2, m_rd;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
      return {7'h15, b, a, 3'h2, d, 7'h33};
   endfunction

   function automatic logic [63:0] m_read(input logic [4:0] i);
      if (i == 5'd0 || i >= 5'd16) return 64'd0;
      if (b1.WB_WE && {1'b0, b1.WB_A} == i) return b1.WB_D;
      return m_rf[i[3:0]];
   endfunction

   task automatic model_step();
      logic [31:0] ins;
      logic [63:0] r1, r2;
      ins = b1.InstrD;
      if (!rst1) begin
         for (int i = 0; i < 16; i++) m_rf[i] = '0;
         {m_valid, m_ctrl, m_d1, m_d2, m_pc, m_imm, m_rs1, m_rs2, m_rd} = '0;
         return;
      end
      r1 = m_read(ins[19:15]);
      r2 = m_read(ins[24:20]);
      if (b1.FLUSH) begin
         {m_valid, m_ctrl, m_d1, m_d2, m_pc, m_imm, m_rs1, m_rs2, m_rd} = '0;
      end else if (b1.STALL) begin
         if (m_valid && b1.WB_WE && m_rs1 != 0 && m_rs1 < 16 && {1'b0, b1.WB_A} == m_rs1) m_d1 = b1.WB_D;
         if (m_valid && b1.WB_WE && m_rs2 != 0 && m_rs2 < 16 && {1'b0, b1.WB_A} == m_rs2) m_d2 = b1.WB_D;
      end else begin
         m_valid = b1.VALID_D;
         m_ctrl  = b1.VALID_D ? b1.CTRL_D : 9'd0;
         m_d1    = r1;
         m_d2    = r2;
         m_pc    = b1.PC_DE;
         m_imm   = ins[31:7];
         m_rs1   = ins[19:15];
         m_rs2   = ins[24:20];
         m_rd    = ins[11:7];
      end
      if (b1.WB_WE && b1.WB_A != 0) m_rf[b1.WB_A] = b1.WB_D;
   endtask

   task automatic drive_rand();
      logic [31:0] ins;
      logic [3:0]  wa;
      ins = $urandom;
      wa  = 4'($urandom);
      if ($urandom_range(0, 9) < 3) ins[19:15] = {1'b0, wa};
      if ($urandom_range(0, 9) < 3) ins[24:20] = {1'b0, wa};
      rst1       = ($urandom_range(0, 49) != 0);
      b1.InstrD  = ins;
      b1.PC_DE   = {$urandom, $urandom};
      b1.VALID_D = ($urandom_range(0, 3) != 0);
      b1.CTRL_D  = 9'($urandom);
      b1.STALL   = ($urandom_range(0, 9) < 3);
      b1.FLUSH   = ($urandom_range(0, 9) == 0);
      b1.WB_WE   = 1'($urandom);
      b1.WB_A    = wa;
      b1.WB_D    = {$urandom, $urandom};
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready_d",  64'(b1.READY_D), 64'(!b1.STALL));
         chk("valid_ex", 64'(b1.VALID_EX), 64'(m_valid));
         chk("ctrl_ex",  64'(b1.CTRL_EX), 64'(m_ctrl));
         chk("d1",       b1.D1, m_d1);
         chk("d2",       b1.D2, m_d2);
         chk("imm",      64'(b1.Imm), 64'(m_imm));
         chk("pc_ex",    b1.PC_EX, m_pc);
         chk("rs1_ex",   64'(b1.RS1_EX), 64'(m_rs1));
         chk("rs2_ex",   64'(b1.RS2_EX), 64'(m_rs2));
         chk("rd_ex",    64'(b1.RD_EX), 64'(m_rd));
      end
   end

   initial begin
      logic [31:0] held;
      {b0.InstrD, b0.PC_DE, b0.VALID_D, b0.CTRL_D, b0.STALL, b0.FLUSH, b0.WB_WE, b0.WB_A, b0.WB_D} = '0;
      {b1.InstrD, b1.PC_DE, b1.VALID_D, b1.CTRL_D, b1.STALL, b1.FLUSH, b1.WB_WE, b1.WB_A, b1.WB_D} = '0;

      // Fill the file so the reset clear is observable.
      b0.WB_WE = 1'b1;
      for (int i = 1; i < 32; i++) begin
         b0.WB_A = 5'(i);
         b0.WB_D = 32'hA5A5_0000 | 32'(i);
         tick();
      end
      rst0 = 1'b0;
      b0.WB_A = 5'd3;
      b0.WB_D = 32'hFFFF;
      b0.FLUSH = 1'b0;
      b0.VALID_D = 1'b1;
      b0.CTRL_D = 9'h1FF;
      tick();
      tick();
      chk("rst_valid_ex", 64'(b0.VALID_EX), 64'd0);
      chk("rst_ctrl_ex", 64'(b0.CTRL_EX), 64'd0);
      chk("rst_pc_ex", 64'(b0.PC_EX), 64'd0);
      chk("rst_ready_hi", 64'(b0.READY_D), 64'd1);
      b0.STALL = 1'b1;
      #1;
      chk("rst_ready_lo", 64'(b0.READY_D), 64'd0);
      b0.STALL = 1'b0;
      rst0 = 1'b1;
      b0.WB_WE = 1'b0;
      b0.CTRL_D = 9'h0;
      for (int i = 1; i < 32; i++) begin
         b0.InstrD = mk(5'(i), 5'(i), 5'd1);
         tick();
         chk("rst_read_d1", 64'(b0.D1), 64'd0);
         chk("rst_read_d2", 64'(b0.D2), 64'd0);
      end

      b0.WB_WE = 1'b1; b0.WB_A = 5'd5; b0.WB_D = 32'hDEAD_BEEF;
      b0.InstrD = mk(5'd5, 5'd0, 5'd2);
      tick();
      chk("bypass_d1", 64'(b0.D1), 64'hDEAD_BEEF);
      chk("bypass_valid", 64'(b0.VALID_EX), 64'd1);
      b0.WB_A = 5'd0; b0.WB_D = 32'h55;
      b0.InstrD = mk(5'd0, 5'd0, 5'd2);
      tick();
      chk("x0_bypass_d1", 64'(b0.D1), 64'd0);
      b0.WB_WE = 1'b0;
      b0.InstrD = mk(5'd5, 5'd5, 5'd2);
      tick();
      chk("stored_x5_d2", 64'(b0.D2), 64'hDEAD_BEEF);

      held = mk(5'd3, 5'd7, 5'd9);
      b0.InstrD = held; b0.PC_DE = 32'h100; b0.CTRL_D = 9'h0A5;
      tick();
      b0.STALL = 1'b1; b0.WB_WE = 1'b1; b0.WB_A = 5'd7; b0.WB_D = 32'h1234;
      b0.InstrD = mk(5'd1, 5'd2, 5'd4); b0.PC_DE = 32'h200; b0.CTRL_D = 9'h1FF;
      #1;
      chk("stall_ready", 64'(b0.READY_D), 64'd0);
      tick();
      chk("refresh_d2", 64'(b0.D2), 64'h1234);
      chk("refresh_d1", 64'(b0.D1), 64'd0);
      chk("stall_pc", 64'(b0.PC_EX), 64'h100);
      chk("stall_ctrl", 64'(b0.CTRL_EX), 64'h0A5);
      chk("stall_rs2", 64'(b0.RS2_EX), 64'd7);
      chk("stall_rd", 64'(b0.RD_EX), 64'd9);
      chk("stall_imm", 64'(b0.Imm), 64'(held[31:7]));
      chk("stall_valid", 64'(b0.VALID_EX), 64'd1);

      b0.WB_WE = 1'b0; b0.FLUSH = 1'b1;
      tick();
      chk("flush_valid", 64'(b0.VALID_EX), 64'd0);
      chk("flush_ctrl", 64'(b0.CTRL_EX), 64'd0);
      chk("flush_pc", 64'(b0.PC_EX), 64'd0);
      chk("flush_d2", 64'(b0.D2), 64'd0);

      b0.FLUSH = 1'b0; b0.STALL = 1'b0; b0.VALID_D = 1'b0;
      tick();
      chk("inval_ctrl", 64'(b0.CTRL_EX), 64'd0);
      chk("inval_valid", 64'(b0.VALID_EX), 64'd0);
      chk("inval_pc", 64'(b0.PC_EX), 64'h200);

      b0.VALID_D = 1'b1;
      tick();
      b0.STALL = 1'b1; rst0 = 1'b0;
      tick();
      chk("rst_stall_valid", 64'(b0.VALID_EX), 64'd0);
      chk("rst_stall_pc", 64'(b0.PC_EX), 64'd0);
      rst0 = 1'b1; b0.STALL = 1'b0;

      rst1 = 1'b0;
      tick();
      tick();
      rst1 = 1'b1;
      b1.WB_WE = 1'b1; b1.WB_A = 4'd15; b1.WB_D = 64'hFFFF_FFFF_0000_0001;
      b1.InstrD = mk(5'd20, 5'd15, 5'd1); b1.VALID_D = 1'b1;
      tick();
      chk("p_oor_d1", b1.D1, 64'd0);
      chk("p_bypass_d2", b1.D2, 64'hFFFF_FFFF_0000_0001);
      b1.WB_WE = 1'b0;
      b1.InstrD = mk(5'd15, 5'd20, 5'd2);
      tick();
      chk("p_x15_d1", b1.D1, 64'hFFFF_FFFF_0000_0001);
      chk("p_oor_d2", b1.D2, 64'd0);

      drive_rand();
      rst1 = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         model_step();
         chk_en = 1'b1;
         drive_rand();
      end
      chk_en = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
